fifo_packetizer: RTL and testbench

//  Drains the byte-wide read side of the bootloader's BRAM FIFO and emits length-delimited packets on a valid/ready byte stream.

---
 rtl/usb_stream_pkg.sv | 21 ++
 rtl/idle_timer.sv | 30 +++
 rtl/fifo_packetizer.sv | 128 ++++++++++++
 tb/tb_fifo_packetizer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/usb_stream_pkg.sv
// Shared constants and state encoding for the USB IN-endpoint byte stream.
// Also provides a clog2 helper for the timer and count widths.
package usb_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SEND = 2'd2
    } pk_state_e;

    localparam int USB_FS_MAX_PKT  = 64;
    localparam int DEFAULT_TIMEOUT = 48000;

    function automatic int clog2(input int value);
        int res;
        res = 1;
        while ((32'd1 << res) < value) res = res + 1;
        return res;
    endfunction

endpackage

// File: rtl/idle_timer.sv
// Clearable up-counter with a terminal flag at LIMIT-1.
// Holds its value whenever en_i is low.
module idle_timer
    import usb_stream_pkg::*;
#(
    parameter int LIMIT = DEFAULT_TIMEOUT,
    parameter int W     = clog2(LIMIT)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign done_o = (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/fifo_packetizer.sv
// Drains a byte FIFO into length-delimited valid/ready packets with lookahead.
// Optional packet counter: define FIFO_PACKETIZER_COUNT_EN.
module fifo_packetizer
    import usb_stream_pkg::*;
#(
    parameter int MAX_PKT = USB_FS_MAX_PKT,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_data_available,
    input  logic [7:0]       fifo_read_data,
    output logic             fifo_read_strobe,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic [CNT_W-1:0] packet_count
);

    localparam int PW = clog2(MAX_PKT);

    pk_state_e     state_q, state_d;
    logic [7:0]    hold_q, hold_d;
    logic [PW-1:0] count_q, count_d;
    logic          last_q, last_d;
    logic          settled_q;
    logic          pop;
    logic          avail;
    logic          timer_done;

    assign avail = fifo_data_available && settled_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        count_d = count_q;
        last_d  = last_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (avail) begin
                    pop     = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (count_q == PW'(MAX_PKT - 1)) begin
                    state_d = SEND;
                    last_d  = 1'b1;
                end else if (avail) begin
                    state_d = SEND;
                    last_d  = 1'b0;
                end else if (timer_done) begin
                    state_d = SEND;
                    last_d  = 1'b1;
                end
            end
            SEND: begin
                if (out_ready) begin
                    count_d = last_q ? '0 : count_q + 1'b1;
                    // Lookahead: a last=0 byte implies data is still queued.
                    if (fifo_data_available) begin
                        pop     = 1'b1;
                        state_d = HOLD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) hold_d = fifo_read_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            count_q   <= '0;
            last_q    <= 1'b0;
            settled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            count_q   <= count_d;
            last_q    <= last_d;
            // Cover the one-cycle RAM read latency after each pop.
            settled_q <= ~pop;
        end
    end

    idle_timer #(
        .LIMIT(TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr_i (pop),
        .en_i  (state_q == HOLD),
        .done_o(timer_done)
    );

    assign fifo_read_strobe = pop && !reset;
    assign out_valid        = (state_q == SEND);
    assign out_data         = hold_q;
    assign out_last         = out_valid && last_q;

`ifdef FIFO_PACKETIZER_COUNT_EN
    logic [CNT_W-1:0] pkt_cnt_q;
    logic             pkt_done;

    assign pkt_done = out_valid && out_ready && last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt_q <= '0;
        end else if (pkt_done) begin
            pkt_cnt_q <= pkt_cnt_q + 1'b1;
        end
    end

    assign packet_count = pkt_cnt_q;
`else
    assign packet_count = '0;
`endif

endmodule

// File: tb/tb_fifo_packetizer.sv
// Directed bench for fifo_packetizer: FIFO model, stream sink, hand-computed
// expectations for timeout, max-size split, stall, lookahead and reset cases.
module tb_fifo_packetizer;

    localparam int MAXP = 64;
    localparam int TMO  = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fifo_data_available;
    logic [7:0]  fifo_read_data;
    logic        fifo_read_strobe;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_last;
    logic [15:0] packet_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fifo_packetizer #(
        .MAX_PKT(MAXP),
        .TIMEOUT(TMO),
        .CNT_W  (16)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .fifo_data_available(fifo_data_available),
        .fifo_read_data     (fifo_read_data),
        .fifo_read_strobe   (fifo_read_strobe),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .out_last           (out_last),
        .packet_count       (packet_count)
    );

    logic [7:0] mem [256];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign fifo_data_available = (wr_ptr != rd_ptr);
    assign fifo_read_data      = mem[rd_ptr[7:0]];

    int         cyc = 0;
    int         pop_cyc = 0;
    int         rx_n = 0;
    logic [7:0] rx_data [256];
    logic       rx_last [256];
    int         rx_cyc  [256];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_read_strobe) begin
            rd_ptr  <= rd_ptr + 1;
            pop_cyc <= cyc;
        end
        if (out_valid && out_ready) begin
            rx_data[rx_n[7:0]] <= out_data;
            rx_last[rx_n[7:0]] <= out_last;
            rx_cyc[rx_n[7:0]]  <= cyc;
            rx_n <= rx_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k;
        k = 0;
        while (rx_n < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (rx_n < n) chk("rx_timeout", rx_n, n);
    endtask

    task automatic wait_valid(input int budget);
        int k;
        k = 0;
        while (!out_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) chk("valid_timeout", {31'd0, out_valid}, 1);
    endtask

    initial begin
        int base;
        int k;
        logic [7:0] b;
        logic [15:0] exp_pc;

        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_last", {31'd0, out_last}, 0);
        chk("rst_data", {24'd0, out_data}, 0);
        chk("rst_strobe", {31'd0, fifo_read_strobe}, 0);
        chk("rst_pcount", {16'd0, packet_count}, 0);
        chk("rst_state", {30'd0, dut.state_q}, 0);
        reset = 1'b0;

        // 1: three preloaded bytes, last one closed by timeout
        out_ready = 1'b1;
        base = rx_n;
        push(8'hA0); push(8'hA1); push(8'hA2);
        wait_rx(base + 3, 300);
        chk("t1_d0", {24'd0, rx_data[base]}, 32'hA0);
        chk("t1_l0", {31'd0, rx_last[base]}, 0);
        chk("t1_d1", {24'd0, rx_data[base+1]}, 32'hA1);
        chk("t1_l1", {31'd0, rx_last[base+1]}, 0);
        chk("t1_d2", {24'd0, rx_data[base+2]}, 32'hA2);
        chk("t1_l2", {31'd0, rx_last[base+2]}, 1);
        chk("t1_a2_lat", rx_cyc[base+2] - pop_cyc, TMO + 1);
        chk("t1_count", {26'd0, dut.count_q}, 0);

        // 2: 130 bytes split into 64 + 64 + 2
        base = rx_n;
        for (int i = 0; i < 130; i++) push(i[7:0]);
        wait_rx(base + 130, 3000);
        for (int i = 0; i < 130; i++) begin
            chk($sformatf("t2_d%0d", i), {24'd0, rx_data[base+i]}, i);
            chk($sformatf("t2_l%0d", i), {31'd0, rx_last[base+i]},
                (i == 63 || i == 127 || i == 129) ? 1 : 0);
        end
        chk("t2_drained", rd_ptr, wr_ptr);

        // 3: sink stalls 100 cycles with a byte presented
        out_ready = 1'b0;
        base = rx_n;
        push(8'hB0); push(8'hB1); push(8'hB2);
        wait_valid(50);
        for (int i = 0; i < 100; i++) begin
            chk("t3_data", {24'd0, out_data}, 32'hB0);
            chk("t3_last", {31'd0, out_last}, 0);
            chk("t3_strobe", {31'd0, fifo_read_strobe}, 0);
            chk("t3_timer", dut.u_timer.cnt_q, 2);
            @(negedge clk);
        end
        out_ready = 1'b1;
        wait_rx(base + 3, 300);
        chk("t3_d0", {24'd0, rx_data[base]}, 32'hB0);
        chk("t3_d1", {24'd0, rx_data[base+1]}, 32'hB1);
        chk("t3_d2", {24'd0, rx_data[base+2]}, 32'hB2);
        chk("t3_l1", {31'd0, rx_last[base+1]}, 0);
        chk("t3_l2", {31'd0, rx_last[base+2]}, 1);

        // 4: second byte arrives just before the timeout
        base = rx_n;
        push(8'h5A);
        k = 0;
        while (dut.u_timer.cnt_q != TMO - 3 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t4_timer_seen", dut.u_timer.cnt_q, TMO - 3);
        push(8'h77);
        wait_rx(base + 1, 20);
        @(negedge clk);
        chk("t4_hold", {24'd0, dut.hold_q}, 32'h77);
        wait_rx(base + 2, 300);
        chk("t4_d0", {24'd0, rx_data[base]}, 32'h5A);
        chk("t4_l0", {31'd0, rx_last[base]}, 0);
        chk("t4_d1", {24'd0, rx_data[base+1]}, 32'h77);
        chk("t4_l1", {31'd0, rx_last[base+1]}, 1);

        // 5: reset while a byte is presented
        out_ready = 1'b0;
        base = rx_n;
        push(8'hC0); push(8'hC1);
        wait_valid(50);
        chk("t5_pre_data", {24'd0, out_data}, 32'hC0);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_valid", {31'd0, out_valid}, 0);
        chk("t5_state", {30'd0, dut.state_q}, 0);
        reset = 1'b0;
        out_ready = 1'b1;
        wait_rx(base + 1, 300);
        chk("t5_d", {24'd0, rx_data[base]}, 32'hC1);
        chk("t5_l", {31'd0, rx_last[base]}, 1);
        chk("t5_drained", rd_ptr, wr_ptr);

        // 6: five timed-out single-byte packets
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base = rx_n;
        for (int i = 0; i < 5; i++) begin
            b = 8'h60 + 8'(i);
            push(b);
            wait_rx(base + i + 1, 300);
            chk($sformatf("t6_d%0d", i), {24'd0, rx_data[base+i]}, {24'd0, b});
            chk($sformatf("t6_l%0d", i), {31'd0, rx_last[base+i]}, 1);
        end
`ifdef FIFO_PACKETIZER_COUNT_EN
        exp_pc = 16'd5;
`else
        exp_pc = 16'd0;
`endif
        chk("t6_pcount", {16'd0, packet_count}, {16'd0, exp_pc});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
